// File: rtl/dmc_pkg.sv
// Shared types and constants for the direct-mapped write-back cache.
// The optional hit/miss statistics are enabled by defining DMC_STATS_EN.
package dmc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        FILL,
        DONE
    } dmc_state_e;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/dmc_wb_cache_if.sv
// Requester-side and RAM-side handshake bundles for dmc_wb_cache.
// The cache is the slave of dmc_req_if and the master of dmc_mem_if.
interface dmc_req_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

interface dmc_mem_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmc_line_array.sv
// Line storage: valid/dirty flags plus tag and data per line.
// Combinational read by index, one write port, single-cycle invalidate-all.
module dmc_line_array #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              inv_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic              rvalid_o,
    output logic              rdirty_o,
    output logic [TAG_W-1:0]  rtag_o,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic              wdirty_i,
    input  logic [TAG_W-1:0]  wtag_i,
    input  logic [DATA_W-1:0] wdata_i
);
    localparam int unsigned LINES = 2 ** IDX_W;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    // Flags alone carry reset/invalidate; tag and data need no clearing.
    always_ff @(posedge clk) begin
        if (inv_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
            dirty_q[widx_i] <= wdirty_i;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rdirty_o = dirty_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/dmc_wb_cache.sv
// Direct-mapped write-back, write-allocate cache with miss FSM and RAM handshake.
// Define DMC_STATS_EN to build saturating hit/miss counters.
module dmc_wb_cache
    import dmc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    dmc_req_if.slave         req,
    dmc_mem_if.master        mem,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;

    dmc_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              line_valid, line_dirty, line_hit;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic              arr_we, arr_dirty, arr_inv;
    logic [DATA_W-1:0] arr_wdata;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              ack;

    assign idx      = addr_q[IDX_W-1:0];
    assign tag      = addr_q[ADDR_W-1:IDX_W];
    assign line_hit = line_valid && (line_tag == tag);
    assign ack      = mem.mem_ack & mem_req_q;

    dmc_line_array #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W)
    ) u_lines (
        .clk      (clk),
        .inv_i    (arr_inv),
        .ridx_i   (idx),
        .rvalid_o (line_valid),
        .rdirty_o (line_dirty),
        .rtag_o   (line_tag),
        .rdata_o  (line_data),
        .we_i     (arr_we),
        .widx_i   (idx),
        .wdirty_i (arr_dirty),
        .wtag_i   (tag),
        .wdata_i  (arr_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        arr_we      = 1'b0;
        arr_dirty   = 1'b0;
        arr_wdata   = wdata_q;
        arr_inv     = rst;

        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    arr_inv = 1'b1;
                end else if (req.req_valid) begin
                    we_d    = req.req_we;
                    addr_d  = req.req_addr;
                    wdata_d = req.req_wdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (line_hit) begin
                    if (we_q) begin
                        arr_we      = 1'b1;
                        arr_dirty   = 1'b1;
                        rsp_rdata_d = wdata_q;
                    end else begin
                        rsp_rdata_d = line_data;
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (line_valid && line_dirty) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {line_tag, idx};
                    mem_wdata_d = line_data;
                    state_d     = WB;
                end else if (!we_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                    state_d    = FILL;
                end else begin
                    arr_we      = 1'b1;
                    arr_dirty   = 1'b1;
                    rsp_rdata_d = wdata_q;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            WB: begin
                if (ack) begin
                    mem_we_d = 1'b0;
                    if (we_q) begin
                        arr_we      = 1'b1;
                        arr_dirty   = 1'b1;
                        rsp_rdata_d = wdata_q;
                        rsp_valid_d = 1'b1;
                        mem_req_d   = 1'b0;
                        state_d     = DONE;
                    end else begin
                        // mem_req stays high: the fill follows the writeback directly.
                        mem_addr_d = addr_q;
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                if (ack) begin
                    arr_we      = 1'b1;
                    arr_dirty   = 1'b0;
                    arr_wdata   = mem.mem_rdata;
                    rsp_rdata_d = mem.mem_rdata;
                    rsp_valid_d = 1'b1;
                    mem_req_d   = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req.req_ready = (state_q == IDLE) && !clr;
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_rdata = rsp_rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

`ifdef DMC_STATS_EN
    logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
    logic             in_lookup;

    assign in_lookup = (state_q == LOOKUP);

    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (in_lookup && line_hit && (hit_q != '1)) begin
            hit_d = hit_q + CNT_W'(1);
        end
        if (in_lookup && !line_hit && (miss_q != '1)) begin
            miss_d = miss_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dmc_wb_cache.sv
// Directed self-checking bench for dmc_wb_cache with a delayed-ack RAM model.
module tb_dmc_wb_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    always #5 clk = ~clk;

    dmc_req_if #(.DATA_W(8), .ADDR_W(8)) rq ();
    dmc_mem_if #(.DATA_W(8), .ADDR_W(8)) mm ();

    dmc_wb_cache #(
        .DATA_W (8),
        .ADDR_W (8),
        .IDX_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .req      (rq),
        .mem      (mm),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] ram [256];
    int         ram_delay  = 3;
    bit         ram_hold   = 1'b0;
    bit         inject_ack = 1'b0;
    int         wait_cnt   = 0;
    int         log_n      = 0;
    logic       log_we    [32];
    logic [7:0] log_addr  [32];
    logic [7:0] log_wdata [32];

    // RAM: acks ram_delay cycles after it first sees mem_req; writebacks update ram[].
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
        ram[8'h35] = 8'hA7;
        ram[8'h75] = 8'h3C;
        mm.mem_ack   = 1'b0;
        mm.mem_rdata = '0;
        forever begin
            @(negedge clk);
            mm.mem_ack = 1'b0;
            if (inject_ack) begin
                mm.mem_ack = 1'b1;
                inject_ack = 1'b0;
            end else if (mm.mem_req && !ram_hold) begin
                if (wait_cnt == ram_delay) begin
                    mm.mem_ack   = 1'b1;
                    mm.mem_rdata = ram[mm.mem_addr];
                    if (mm.mem_we) ram[mm.mem_addr] = mm.mem_wdata;
                    if (log_n < 32) begin
                        log_we[log_n]    = mm.mem_we;
                        log_addr[log_n]  = mm.mem_addr;
                        log_wdata[log_n] = mm.mem_wdata;
                    end
                    log_n++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic we, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        rq.req_valid = 1'b1;
        rq.req_we    = we;
        rq.req_addr  = a;
        rq.req_wdata = d;
        #1;
        check("req_ready", 16'(rq.req_ready), 16'd1);
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
    endtask

    // lat/first_mreq are cycle numbers with the accept cycle as 0.
    task automatic wait_rsp(output int lat, output logic [7:0] rd, output int first_mreq);
        int n   = 0;
        bit got = 1'b0;
        first_mreq = 0;
        while (!got && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (mm.mem_req === 1'b1 && first_mreq == 0) first_mreq = n + 1;
            if (rq.rsp_valid === 1'b1) got = 1'b1;
        end
        check("rsp_timeout", 16'(got), 16'd1);
        lat = n + 1;
        rd  = rq.rsp_rdata;
        @(posedge clk);
        #1;
        check("rsp_pulse", 16'(rq.rsp_valid), 16'd0);
    endtask

    task automatic txn(input string name, input logic we, input logic [7:0] a, input logic [7:0] d,
                       input int exp_lat, input logic [7:0] exp_rd, input int exp_ntxn,
                       input int exp_mreq);
        int         lat, fm, base;
        logic [7:0] rd;
        base = log_n;
        send_req(we, a, d);
        wait_rsp(lat, rd, fm);
        check({name, "_lat"}, 16'(lat), 16'(exp_lat));
        check({name, "_rdata"}, 16'(rd), 16'(exp_rd));
        check({name, "_ntxn"}, 16'(log_n - base), 16'(exp_ntxn));
        check({name, "_mreq_cyc"}, 16'(fm), 16'(exp_mreq));
    endtask

    initial begin
        int b;
        rst          = 1'b1;
        clr          = 1'b0;
        rq.req_valid = 1'b0;
        rq.req_we    = 1'b0;
        rq.req_addr  = '0;
        rq.req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", 16'(rq.req_ready), 16'd1);
        check("rst_rsp_valid", 16'(rq.rsp_valid), 16'd0);
        check("rst_mem_req", 16'(mm.mem_req), 16'd0);
        check("rst_mem_we", 16'(mm.mem_we), 16'd0);
        check("rst_mem_addr", 16'(mm.mem_addr), 16'd0);
        check("rst_mem_wdata", 16'(mm.mem_wdata), 16'd0);
        check("rst_rsp_rdata", 16'(rq.rsp_rdata), 16'd0);
        check("rst_hit_cnt", hit_cnt, 16'd0);
        check("rst_miss_cnt", miss_cnt, 16'd0);

        // Clean read miss: mem_req at cycle 2, ack at 5, rsp at 6.
        b = log_n;
        txn("rd35_miss", 1'b0, 8'h35, 8'h00, 6, 8'hA7, 1, 2);
        check("rd35_fill_we", 16'(log_we[b]), 16'd0);
        check("rd35_fill_addr", 16'(log_addr[b]), 16'h35);
        txn("rd35_hit", 1'b0, 8'h35, 8'h00, 2, 8'hA7, 0, 0);

        // Write hit then conflicting read: writeback then fill.
        txn("wr35_hit", 1'b1, 8'h35, 8'h11, 2, 8'h11, 0, 0);
        b = log_n;
        txn("rd75_dirty", 1'b0, 8'h75, 8'h00, 10, 8'h3C, 2, 2);
        check("wb_we", 16'(log_we[b]), 16'd1);
        check("wb_addr", 16'(log_addr[b]), 16'h35);
        check("wb_wdata", 16'(log_wdata[b]), 16'h11);
        check("fill75_we", 16'(log_we[b+1]), 16'd0);
        check("fill75_addr", 16'(log_addr[b+1]), 16'h75);
        check("ram35_after_wb", 16'(ram[8'h35]), 16'h11);

        // Write miss on an empty line allocates without RAM traffic.
        txn("wr42_miss", 1'b1, 8'h42, 8'h5C, 2, 8'h5C, 0, 0);
        txn("rd42_hit", 1'b0, 8'h42, 8'h00, 2, 8'h5C, 0, 0);

        // clr beats a simultaneous request and discards the dirty line.
        @(negedge clk);
        clr          = 1'b1;
        rq.req_valid = 1'b1;
        rq.req_we    = 1'b0;
        rq.req_addr  = 8'h42;
        #1;
        check("clr_ready", 16'(rq.req_ready), 16'd0);
        @(posedge clk);
        #1;
        clr          = 1'b0;
        rq.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("clr_no_rsp", 16'(rq.rsp_valid), 16'd0);
        check("clr_no_mreq", 16'(mm.mem_req), 16'd0);
        b = log_n;
        txn("rd42_after_clr", 1'b0, 8'h42, 8'h00, 6, 8'h18, 1, 2);
        check("rd42_fill_we", 16'(log_we[b]), 16'd0);
        check("rd42_fill_addr", 16'(log_addr[b]), 16'h42);

        // Reset while a fill is outstanding; a late ack must be ignored.
        ram_hold = 1'b1;
        send_req(1'b0, 8'h35, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("fill_pending_req", 16'(mm.mem_req), 16'd1);
        check("fill_pending_we", 16'(mm.mem_we), 16'd0);
        check("fill_pending_addr", 16'(mm.mem_addr), 16'h35);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        inject_ack = 1'b1;
        check("midrst_mem_req", 16'(mm.mem_req), 16'd0);
        check("midrst_mem_addr", 16'(mm.mem_addr), 16'd0);
        check("midrst_rsp_rdata", 16'(rq.rsp_rdata), 16'd0);
        check("midrst_ready", 16'(rq.req_ready), 16'd1);
        @(posedge clk);
        #1;
        check("late_ack_rsp", 16'(rq.rsp_valid), 16'd0);
        check("late_ack_mreq", 16'(mm.mem_req), 16'd0);
        check("late_ack_ready", 16'(rq.req_ready), 16'd1);
        ram_hold = 1'b0;
        b = log_n;
        txn("rd35_after_rst", 1'b0, 8'h35, 8'h00, 6, 8'h11, 1, 2);
        check("rd35r_fill_addr", 16'(log_addr[b]), 16'h35);

        // Counters since reset: one miss above, three hits and one more miss here.
        txn("rd35_h1", 1'b0, 8'h35, 8'h00, 2, 8'h11, 0, 0);
        txn("rd35_h2", 1'b0, 8'h35, 8'h00, 2, 8'h11, 0, 0);
        txn("rd35_h3", 1'b0, 8'h35, 8'h00, 2, 8'h11, 0, 0);
        txn("rd42_m2", 1'b0, 8'h42, 8'h00, 6, 8'h18, 1, 2);
`ifdef DMC_STATS_EN
        check("stat_hit", hit_cnt, 16'd3);
        check("stat_miss", miss_cnt, 16'd2);
        @(negedge clk);
        force dut.hit_q = 16'hFFFF;
        #1;
        release dut.hit_q;
        txn("rd35_sat", 1'b0, 8'h35, 8'h00, 2, 8'h11, 0, 0);
        check("stat_hit_sat", hit_cnt, 16'hFFFF);
        check("stat_miss_sat", miss_cnt, 16'd2);
`else
        check("nostat_hit", hit_cnt, 16'd0);
        check("nostat_miss", miss_cnt, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
